// File: rtl/irq_queue_pkg.sv
// Shared constants for the interrupt queue: default geometry, payload and record
// layout, and the source IDs the arbiter uses when picking a pending record.
package rintaro_pkg;

    localparam int DEF_DEPTH   = 4;
    localparam int DEF_VEC_W   = 32;
    localparam int DATA_W      = 16;
    localparam int KEY_W       = 9;
    localparam int SYNC_STAGES = 2;

    // A record is {payload[DATA_W-1:0], vector[VEC_W-1:0]}, vector in the low bits.
    localparam int REC_DATA_W  = DATA_W;

    typedef enum logic [0:0] {
        SRC_KEY = 1'b0,
        SRC_BP  = 1'b1
    } src_e;

    function automatic logic [DATA_W-1:0] key_payload(input logic [KEY_W-1:0] code);
        return {{(DATA_W-KEY_W){1'b0}}, code};
    endfunction

endpackage

// File: rtl/irq_queue_if.sv
// Bundle of event-source, CPU-side and status signals of the interrupt queue.
// master = the surrounding system (keyboard, memory, CPU); slave = the queue.
interface irq_queue_if import rintaro_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int VEC_W = DEF_VEC_W
) ();

    logic                     keyPressed;
    logic [KEY_W-1:0]         keyCode;
    logic                     keyEn;
    logic                     bpHit;
    logic [DATA_W-1:0]        bpData;
    logic [VEC_W-1:0]         vector;
    logic                     intEn;
    logic                     ack;
    logic                     irq;
    logic [DATA_W-1:0]        intData;
    logic [VEC_W-1:0]         intAddr;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [7:0]               dropCount;

    modport master (
        output keyPressed, keyCode, keyEn, bpHit, bpData, vector, intEn, ack,
        input  irq, intData, intAddr, count, overflow, dropCount
    );

    modport slave (
        input  keyPressed, keyCode, keyEn, bpHit, bpData, vector, intEn, ack,
        output irq, intData, intAddr, count, overflow, dropCount
    );

endinterface

// File: rtl/irq_queue_fifo.sv
// Small flop-based synchronous FIFO; the head entry is visible combinationally
// and reads as zero while the FIFO is empty.
module irq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtrReg;
    logic [PW-1:0]    rdPtrReg;
    logic [PW:0]      countReg;
    logic             doPush;
    logic             doPop;

    assign empty  = (countReg == '0);
    assign full   = (countReg == (PW+1)'(DEPTH));
    assign doPop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrReg] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PW'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PW'(1);
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + (PW+1)'(1);
                2'b01:   countReg <= countReg - (PW+1)'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    assign count = countReg;
    assign head  = empty ? '0 : mem[rdPtrReg];

endmodule

// File: rtl/irq_queue.sv
// Interrupt queue: captures keyboard and breakpoint events into one-deep pending
// slots, arbitrates them into a FIFO and raises irq to the CPU for the head record.
module irq_queue import rintaro_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int VEC_W = DEF_VEC_W
) (
    input  logic       clk,
    input  logic       rst,
    irq_queue_if.slave bus
);

    localparam int REC_W = DATA_W + VEC_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic [SYNC_STAGES:0] bpSyncReg;
    logic                 kpPrevReg;
    logic                 keyEvent;
    logic                 bpEvent;

    logic                 keyValidReg;
    logic                 bpValidReg;
    logic [REC_W-1:0]     keyRecReg;
    logic [REC_W-1:0]     bpRecReg;
    logic                 keyDrop;
    logic                 bpDrop;

    logic                 overflowReg;
    logic [7:0]           dropCountReg;
    logic [8:0]           dropSum;
    logic                 irqReg;
    logic                 gap;
    logic                 canPush;
    logic                 pushReq;
    src_e                 grantSrc;
    logic [REC_W-1:0]     pushRec;

    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [CW-1:0]        fifoCount;
    logic [REC_W-1:0]     fifoHead;

    // Two synchronizer flops plus one delay flop; the event is the synced rising edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bpSyncReg <= '0;
            kpPrevReg <= 1'b0;
        end else begin
            bpSyncReg <= {bpSyncReg[SYNC_STAGES-1:0], bus.bpHit};
            kpPrevReg <= bus.keyPressed;
        end
    end

    assign bpEvent  = bpSyncReg[SYNC_STAGES-1] && !bpSyncReg[SYNC_STAGES];
    assign keyEvent = bus.keyPressed && !kpPrevReg && bus.keyEn;
    assign keyDrop  = keyEvent && keyValidReg;
    assign bpDrop   = bpEvent && bpValidReg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            keyValidReg <= 1'b0;
            keyRecReg   <= '0;
        end else if (keyEvent && !keyValidReg) begin
            keyValidReg <= 1'b1;
            keyRecReg   <= {key_payload(bus.keyCode), bus.vector};
        end else if (pushReq && (grantSrc == SRC_KEY)) begin
            keyValidReg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bpValidReg <= 1'b0;
            bpRecReg   <= '0;
        end else if (bpEvent && !bpValidReg) begin
            bpValidReg <= 1'b1;
            bpRecReg   <= {bus.bpData, bus.vector};
        end else if (pushReq && (grantSrc == SRC_BP)) begin
            bpValidReg <= 1'b0;
        end
    end

    // gap marks the edge on which the CPU's acknowledge actually pops the head.
    assign gap     = bus.ack && irqReg && !fifoEmpty;
    assign canPush = !fifoFull || gap;

    always_comb begin
        grantSrc = SRC_BP;
        pushReq  = 1'b0;
        if (bpValidReg) begin
            grantSrc = SRC_BP;
            pushReq  = canPush;
        end else if (keyValidReg) begin
            grantSrc = SRC_KEY;
            pushReq  = canPush;
        end
    end

    assign pushRec = (grantSrc == SRC_BP) ? bpRecReg : keyRecReg;
    assign dropSum = {1'b0, dropCountReg} + 9'(keyDrop) + 9'(bpDrop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflowReg  <= 1'b0;
            dropCountReg <= '0;
            irqReg       <= 1'b0;
        end else begin
            overflowReg  <= overflowReg | keyDrop | bpDrop;
            dropCountReg <= dropSum[8] ? 8'hFF : dropSum[7:0];
            irqReg       <= bus.intEn && !fifoEmpty && !gap;
        end
    end

    irq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pushReq),
        .pushData (pushRec),
        .pop      (gap),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount),
        .head     (fifoHead)
    );

    assign bus.irq       = irqReg;
    assign bus.intData   = fifoHead[REC_W-1 -: DATA_W];
    assign bus.intAddr   = fifoHead[VEC_W-1:0];
    assign bus.count     = fifoCount;
    assign bus.overflow  = overflowReg;
    assign bus.dropCount = dropCountReg;

endmodule

// File: tb/tb_irq_queue.sv
// Randomised and directed bench for irq_queue: a behavioural queue model predicts
// every cycle's status, and a scoreboard checks the record handed over on each pop.
module tb_irq_queue;
    import rintaro_pkg::*;

    localparam int DEPTH = 4;
    localparam int VEC_W = 32;

    typedef struct {
        logic [15:0]      data;
        logic [VEC_W-1:0] addr;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    irq_queue_if #(.DEPTH(DEPTH), .VEC_W(VEC_W)) bus ();

    irq_queue #(.DEPTH(DEPTH), .VEC_W(VEC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state (describes the queue after the most recent clock edge).
    rec_t mFifo[$];
    rec_t sbQ[$];
    bit   mKeyV, mBpV;
    rec_t mKeyRec, mBpRec;
    bit   mIrq, mOvf, mKpPrev;
    int   mDrops;
    bit   mBpHist[3];   // bpHit as sampled 1, 2 and 3 edges ago

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the queue's rules to the inputs present for the coming edge.
    task automatic model_edge();
        bit   pop, canPush, bpEv, keyEv, preKeyV, preBpV, anyFifo;
        rec_t r;
        if (!rst) begin
            mFifo.delete();
            sbQ.delete();
            mKeyV = 0; mBpV = 0; mIrq = 0; mOvf = 0; mDrops = 0; mKpPrev = 0;
            mBpHist = '{0, 0, 0};
            return;
        end
        anyFifo = (mFifo.size() > 0);
        pop     = bus.ack && mIrq && anyFifo;
        canPush = (mFifo.size() < DEPTH) || pop;
        bpEv    = mBpHist[1] && !mBpHist[2];
        keyEv   = bus.keyPressed && !mKpPrev && bus.keyEn;
        preKeyV = mKeyV;
        preBpV  = mBpV;

        if (pop) void'(mFifo.pop_front());
        if (preBpV && canPush) begin
            mFifo.push_back(mBpRec); sbQ.push_back(mBpRec); mBpV = 0;
        end else if (preKeyV && canPush) begin
            mFifo.push_back(mKeyRec); sbQ.push_back(mKeyRec); mKeyV = 0;
        end

        if (bpEv) begin
            if (preBpV) begin mOvf = 1; mDrops = (mDrops < 255) ? mDrops + 1 : 255; end
            else begin r.data = bus.bpData; r.addr = bus.vector; mBpRec = r; mBpV = 1; end
        end
        if (keyEv) begin
            if (preKeyV) begin mOvf = 1; mDrops = (mDrops < 255) ? mDrops + 1 : 255; end
            else begin r.data = {7'b0, bus.keyCode}; r.addr = bus.vector; mKeyRec = r; mKeyV = 1; end
        end

        mIrq    = bus.intEn && anyFifo && !pop;
        mKpPrev = bus.keyPressed;
        mBpHist[2] = mBpHist[1];
        mBpHist[1] = mBpHist[0];
        mBpHist[0] = bus.bpHit;
    endtask

    task automatic check_state();
        rec_t h;
        h.data = '0;
        h.addr = '0;
        if (mFifo.size() > 0) h = mFifo[0];
        chk("irq",       64'(bus.irq),       64'(mIrq));
        chk("count",     64'(bus.count),     64'(mFifo.size()));
        chk("overflow",  64'(bus.overflow),  64'(mOvf));
        chk("dropCount", 64'(bus.dropCount), 64'(mDrops));
        chk("intData",   64'(bus.intData),   64'(h.data));
        chk("intAddr",   64'(bus.intAddr),   64'(h.addr));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic key_event(input logic [8:0] code);
        bus.keyPressed = 1'b1;
        bus.keyCode    = code;
        step();
        bus.keyPressed = 1'b0;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Scoreboard monitor: every accepted acknowledge must hand over the oldest record.
    initial begin : monitor
        rec_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.ack && bus.irq) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got data %0h, no record expected", bus.intData);
                end else begin
                    e = sbQ.pop_front();
                    $display("pop data=%04h addr=%08h", bus.intData, bus.intAddr);
                    chk("pop_data", 64'(bus.intData), 64'(e.data));
                    chk("pop_addr", 64'(bus.intAddr), 64'(e.addr));
                end
            end
        end
    end

    initial begin : stimulus
        int bpHold;
        bus.keyPressed = 0; bus.keyCode = '0; bus.keyEn = 1; bus.bpHit = 0;
        bus.bpData = '0; bus.vector = '0; bus.intEn = 1; bus.ack = 0;
        rst = 0;
        idle(3);
        rst = 1;
        idle(2);

        // Single key, then acknowledge.
        bus.vector = 32'h0000_0100;
        key_event(9'h1C1);
        idle(1);
        bus.ack = 1; step(); bus.ack = 0;
        idle(2);

        // Breakpoint and key events aligned after synchronization.
        bus.bpData = 16'hBEEF; bus.bpHit = 1; bus.vector = 32'h0000_0200;
        idle(2);
        bus.keyPressed = 1; bus.keyCode = 9'h05A; step();
        bus.keyPressed = 0; bus.bpHit = 0;
        idle(3);
        bus.ack = 1; idle(6); bus.ack = 0;
        idle(2);

        // Fill past capacity: four queued, one pending, one dropped; one ack refills.
        for (int i = 0; i < 6; i++) begin
            bus.vector = 32'h1000 + 32'(i);
            key_event(9'(9'h100 + i));
        end
        bus.ack = 1; step(); bus.ack = 0;
        idle(2);
        bus.ack = 1; idle(14); bus.ack = 0;

        // Two records, acknowledge held high throughout.
        rst = 0; step(); rst = 1;
        key_event(9'h011); key_event(9'h022);
        bus.ack = 1; idle(8); bus.ack = 0;

        // Interrupts disabled while queue fills, then re-enabled.
        bus.intEn = 0;
        key_event(9'h031); key_event(9'h032); key_event(9'h033);
        idle(2);
        bus.intEn = 1; idle(2);
        bus.ack = 1; idle(8); bus.ack = 0;

        // Reset with three queued records and a key still pending.
        bus.intEn = 0;
        key_event(9'h041); key_event(9'h042); key_event(9'h043);
        bus.keyPressed = 1; bus.keyCode = 9'h044; step();
        bus.keyPressed = 0; rst = 0; step();
        rst = 1; idle(4);
        bus.intEn = 1;

        // Drop counter saturation.
        bus.intEn = 0;
        for (int i = 0; i < 270; i++) key_event(9'($urandom));
        rst = 0; step(); rst = 1;
        bus.intEn = 1;

        // Random traffic.
        bpHold = 0;
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 199) != 0);
            bus.keyPressed = ($urandom_range(0, 2) == 0);
            bus.keyCode    = 9'($urandom);
            bus.keyEn      = ($urandom_range(0, 4) != 0);
            bus.vector     = $urandom;
            bus.intEn      = ($urandom_range(0, 6) != 0);
            bus.ack        = ($urandom_range(0, 1) == 1);
            if (bpHold > 0) begin
                bpHold--;
            end else begin
                bus.bpHit = !bus.bpHit;
                if (bus.bpHit) bus.bpData = 16'($urandom);
                bpHold = $urandom_range(0, 5);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_queue.md
IRQ_QUEUE -- requirements
Module: irq_queue

Interface
REQ-001 Parameter DEPTH, 4, interrupt-record FIFO depth; power of two, 2..16.
REQ-002 Parameter VEC_W, 32, interrupt vector width.
REQ-003 clk  in  1  single clock for all state.
REQ-004 rst  in  1  reset; synchronous, active-low (rst=0 resets on the next clk rising edge).
REQ-005 keyPressed  in  1  level from keyboard reader; a rising edge is one key event.
REQ-006 keyCode  in  9  scancode; valid on the cycle keyPressed rises.
REQ-007 keyEn  in  1  keyboard interrupt enable (switch[0]); key events with keyEn=0 are discarded without counting.
REQ-008 bpHit  in  1  breakpoint level from memory (clk1 domain); asynchronous to clk.
REQ-009 bpData  in  16  breakpoint payload; stable while bpHit high.
REQ-010 vector  in  VEC_W  current interrupt vector from memory.
REQ-011 intEn  in  1  CPU interrupt enable; gates irq only, never the queue.
REQ-012 ack  in  1  turnOffIRQ from CPU; pops the head record.
REQ-013 irq  out  1  interrupt request to CPU.
REQ-014 intData  out  16  head payload (key: {7'b0,keyCode}; bp: bpData).
REQ-015 intAddr  out  VEC_W  head vector, latched at enqueue.
REQ-016 count  out  clog2(DEPTH)+1  occupancy.
REQ-017 overflow  out  1  sticky; set on any dropped event.
REQ-018 dropCount  out  8  dropped events, saturating at 255.

Function
REQ-019 bpHit shall pass a 2-flop synchronizer plus one delay flop; a bp event is synced-high and delayed-low (3-cycle input latency).
REQ-020 Key event: keyPressed=1 and previous-cycle keyPressed=0 and keyEn=1; keyCode captured that cycle.
REQ-021 Each source shall own a 1-deep pending register {payload, vector captured at event cycle}.
REQ-022 Arbiter writes at most one pending record per cycle into the FIFO; bp pending has priority over key pending.
REQ-023 A pending record is written the cycle after capture if FIFO not full (or popped same cycle); otherwise held.
REQ-024 A new event on a source whose pending is still occupied is dropped: overflow<=1, dropCount+1 (saturate).
REQ-025 Simultaneous bp and key events: both captured; bp enqueued at N+1, key at N+2.
REQ-026 irq is registered: irq=intEn and count>0 and not gap; gap is a one-cycle flag set by an accepted pop.
REQ-027 ack with irq=1 pops head at that edge; irq shall be 0 the following cycle, reasserting one cycle later if count>0.
REQ-028 ack while count=0 or irq=0 shall be ignored (no pop, no state change).
REQ-029 Pop and push same cycle: both performed, count unchanged; when full, the push is accepted only because of the pop.
REQ-030 intData/intAddr show the head record combinationally from FIFO storage; 0 when empty.
REQ-031 Pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.
REQ-032 intEn low: queue keeps filling, irq forced 0; irq rises the cycle after intEn returns high if count>0.

Reset
REQ-033 rst=0 clears pointers, count, pending registers, synchronizer, edge-detect flops, gap, overflow, dropCount; irq, intData, intAddr, count = 0.
REQ-034 Reset mid-operation discards all queued and pending records; events in the reset cycle are lost, not counted.

Structure
REQ-035 Package rintaro_pkg holds DEPTH default, VEC_W, DATA_W=16, record-layout constants, source-ID encodings.
REQ-036 One sub-module irq_fifo: synchronous FIFO (push, pop, full, empty, count, head) with flop storage; the arbiter, synchronizer and drop logic stay in irq_queue.

Verification
REQ-037 Key 0x1C1, keyEn=1, vector=0x00000100, intEn=1 -> irq high 2 cycles after edge, intData=0x01C1, intAddr=0x00000100; ack -> irq 0 next cycle, count=0.
REQ-038 bpHit rise and key edge aligned after sync, bpData=0xBEEF, key 0x05A -> pops return 0xBEEF then 0x005A.
REQ-039 Five key events, no ack (DEPTH=4) -> count=4, fifth held in pending; sixth -> overflow=1, dropCount=1; one ack -> pending enqueues, count stays 4.
REQ-040 Two queued records, ack held high continuously -> irq pattern 1,0,1,0 with exactly two pops; spare acks ignored.
REQ-041 intEn=0, three events -> irq=0, count=3; intEn=1 -> irq next cycle, head is first event.
REQ-042 rst=0 asserted with count=3 and key pending -> next cycle all outputs 0, no later spurious enqueue.
